// File: rtl/cpu_reg_package.sv
// Shared CPU-bus register constants: default bus widths and interrupt controller map.
package cpu_reg_package;

    localparam int unsigned address_width = 32;
    localparam int unsigned data_width    = 32;

    localparam logic [31:0] IRQ_BASE_ADDR = 32'h0000_9000;

    // Byte offsets from IRQ_BASE_ADDR; word index is bits [4:2].
    localparam logic [4:0] IRQ_STATUS_OFS  = 5'h00;
    localparam logic [4:0] IRQ_PENDING_OFS = 5'h04;
    localparam logic [4:0] IRQ_ENABLE_OFS  = 5'h08;
    localparam logic [4:0] IRQ_MODE_OFS    = 5'h0C;
    localparam logic [4:0] IRQ_CLAIM_OFS   = 5'h10;

endpackage

// File: rtl/irq_src_sync.sv
// Per-source synchroniser chain followed by a one-flop rising-edge detector.
module irq_src_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic src_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic                   sync_prev_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stage_q     <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            stage_q     <= {stage_q[SYNC_STAGES-2:0], src_i};
            sync_prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~sync_prev_q;

endmodule

// File: rtl/bus_irq_ctrl.sv
// Memory-mapped interrupt controller: per-source edge/level pending latches, enable mask,
// lowest-index-first claim register and a single registered CPU interrupt line.
module bus_irq_ctrl
    import cpu_reg_package::*;
#(
    parameter int unsigned            ADDR_WIDTH  = address_width,
    parameter int unsigned            DATA_WIDTH  = data_width,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = ADDR_WIDTH'(IRQ_BASE_ADDR),
    parameter int unsigned            NUM_SRC     = 8,
    parameter int unsigned            SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  irq_o,
    input  logic [NUM_SRC-1:0]    src_i
);

    logic [NUM_SRC-1:0]    sync;
    logic [NUM_SRC-1:0]    rise;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    enable_q;
    logic [NUM_SRC-1:0]    mode_q, mode_new;
    logic [NUM_SRC-1:0]    active, claim_sel, claim_clr, w1c, switch_on;
    logic [DATA_WIDTH-1:0] claim_val;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic                  irq_q;
    logic                  hit, rd, wr;
    logic [2:0]            offset;
    logic                  unused_bits;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        irq_src_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .src_i  (src_i[n]),
            .sync_o (sync[n]),
            .rise_o (rise[n])
        );
    end

    assign hit    = address_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
    assign offset = address_i[4:2];
    assign rd     = hit & ~we_i;
    assign wr     = hit & we_i;

    assign unused_bits = ^{address_i[1:0], data_i[DATA_WIDTH-1:NUM_SRC]};

    // Lowest-index active source; isolate the lowest set bit for the claim-clear.
    assign active    = pending_q & enable_q;
    assign claim_sel = active & (~active + NUM_SRC'(1));

    always_comb begin
        claim_val = '0;
        for (int n = int'(NUM_SRC) - 1; n >= 0; n--) begin
            if (active[n]) claim_val = DATA_WIDTH'(n + 1);
        end
    end

    assign claim_clr = (rd && offset == IRQ_CLAIM_OFS[4:2]) ? claim_sel : '0;
    assign w1c       = (wr && offset == IRQ_PENDING_OFS[4:2]) ? data_i[NUM_SRC-1:0] : '0;
    assign mode_new  = (wr && offset == IRQ_MODE_OFS[4:2]) ? data_i[NUM_SRC-1:0] : mode_q;
    assign switch_on = mode_new & ~mode_q;

    // Level sources track sync; edge sources set on rise (set beats clear), and a
    // source just switched into edge mode restarts from its rise alone.
    assign pending_d = (~mode_new & sync)
                     | (mode_new & (rise | (pending_q & ~switch_on & ~w1c & ~claim_clr)));

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (offset)
                IRQ_STATUS_OFS[4:2]:  rdata_d[NUM_SRC-1:0] = sync;
                IRQ_PENDING_OFS[4:2]: rdata_d[NUM_SRC-1:0] = pending_q;
                IRQ_ENABLE_OFS[4:2]:  rdata_d[NUM_SRC-1:0] = enable_q;
                IRQ_MODE_OFS[4:2]:    rdata_d[NUM_SRC-1:0] = mode_q;
                IRQ_CLAIM_OFS[4:2]:   rdata_d              = claim_val;
                default:              rdata_d              = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mode_q    <= mode_new;
            rdata_q   <= rdata_d;
            irq_q     <= |active;
            if (wr && offset == IRQ_ENABLE_OFS[4:2]) enable_q <= data_i[NUM_SRC-1:0];
        end
    end

    assign rdata_o = rdata_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_bus_irq_ctrl.sv
// Directed bench for bus_irq_ctrl with a read-data scoreboard queue.
module tb_bus_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_9000;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] address_i;
    logic        we_i;
    logic [31:0] data_i;
    logic [31:0] rdata_o;
    logic        irq_o;
    logic [7:0]  src_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bus_irq_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .NUM_SRC    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .address_i(address_i),
        .we_i     (we_i),
        .data_i   (data_i),
        .rdata_o  (rdata_o),
        .irq_o    (irq_o),
        .src_i    (src_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        address_i = 32'h0;
        we_i      = 1'b0;
        data_i    = 32'h0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        address_i = addr;
        we_i      = 1'b1;
        data_i    = d;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        address_i = addr;
        we_i      = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk);
        check(tag, rdata_o, exp_q.pop_front());
        idle();
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'b0, irq_o}, {31'b0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0;
        src_i   = 8'h00;
        idle();
        cycles(2);
        check_irq("rst_irq", 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        reset_i = 1'b1;
        cycles(1);

        // Edge latency: src edge to irq is SYNC_STAGES+2 cycles.
        wr(BASE + 32'h08, 32'h01);
        wr(BASE + 32'h0C, 32'h01);
        src_i[0] = 1'b1;
        cycles(3);
        check_irq("lat_3cyc", 1'b0);
        src_i[0] = 1'b0;
        cycles(1);
        check_irq("lat_4cyc", 1'b1);
        rd("edge_pending", BASE + 32'h04, 32'h01);
        wr(BASE + 32'h04, 32'h01);
        check_irq("w1c_plus1", 1'b1);
        cycles(1);
        check_irq("w1c_plus2", 1'b0);
        rd("edge_pending_clr", BASE + 32'h04, 32'h00);

        // Priority claim, back to back.
        wr(BASE + 32'h0C, 32'hFF);
        wr(BASE + 32'h08, 32'hFF);
        src_i = 8'h24;
        cycles(4);
        src_i = 8'h00;
        cycles(2);
        check_irq("claim_irq_before", 1'b1);
        rd("claim_first", BASE + 32'h10, 32'd3);
        rd("claim_second", BASE + 32'h10, 32'd6);
        rd("claim_none", BASE + 32'h10, 32'd0);
        check_irq("claim_irq_after", 1'b0);
        rd("claim_pending", BASE + 32'h04, 32'h00);

        // Level mode: W1C and claim do not clear.
        wr(BASE + 32'h0C, 32'h00);
        wr(BASE + 32'h08, 32'h80);
        src_i[7] = 1'b1;
        cycles(4);
        check_irq("level_irq", 1'b1);
        wr(BASE + 32'h04, 32'h80);
        rd("level_claim", BASE + 32'h10, 32'd8);
        rd("level_pending", BASE + 32'h04, 32'h80);
        src_i[7] = 1'b0;
        cycles(3);
        check_irq("level_fall_3cyc", 1'b1);
        cycles(1);
        check_irq("level_fall_4cyc", 1'b0);

        // Set/clear collision: W1C commits on the edge where the rise is latched.
        wr(BASE + 32'h0C, 32'hFF);
        wr(BASE + 32'h08, 32'h00);
        src_i[1] = 1'b1;
        cycles(2);
        wr(BASE + 32'h04, 32'h02);
        rd("collide_pending", BASE + 32'h04, 32'h02);
        rd("status_level", BASE + 32'h00, 32'h02);
        wr(BASE + 32'h04, 32'h02);
        rd("collide_cleared", BASE + 32'h04, 32'h00);

        // Decode: unused offsets, out-of-window address, register width.
        rd("ofs14_read", BASE + 32'h14, 32'h0);
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        rd("ofs14_after_wr", BASE + 32'h14, 32'h0);
        rd("no_hit_read", BASE + 32'h20, 32'h0);
        wr(BASE + 32'h08, 32'hFFFF_FFFF);
        rd("enable_width", BASE + 32'h08, 32'h0000_00FF);
        rd("mode_readback", BASE + 32'h0C, 32'h0000_00FF);

        // Reset mid-operation with PENDING=0x05 and irq high.
        src_i = 8'h00;
        cycles(3);
        wr(BASE + 32'h08, 32'h05);
        src_i = 8'h05;
        cycles(4);
        src_i = 8'h00;
        rd("pre_rst_pending", BASE + 32'h04, 32'h05);
        check_irq("pre_rst_irq", 1'b1);
        address_i = BASE + 32'h04;
        @(posedge clk);
        #2 reset_i = 1'b0;
        #1;
        check_irq("async_rst_irq", 1'b0);
        check("async_rst_rdata", rdata_o, 32'h0);
        @(negedge clk);
        idle();
        cycles(1);
        reset_i = 1'b1;
        cycles(1);
        rd("post_rst_pending", BASE + 32'h04, 32'h0);
        rd("post_rst_enable", BASE + 32'h08, 32'h0);
        rd("post_rst_mode", BASE + 32'h0C, 32'h0);
        check_irq("post_rst_irq", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
